axi4_lite_regfile_slave: RTL
============================

Name: axi4_lite_regfile_slave

Overview:
- Parametrised AXI4-Lite register-file slave. Next generation of the fixed 32-bit register slave.
- Generalises data width and register count. Adds per-register read-only masking.
- Accepts the AW and W channels independently, in either order.
- Returns SLVERR for out-of-range and read-only accesses.
- Sits behind the AXI4-Lite interconnect as the control/status register bank for a peripheral.

Parameters:
- DATA_W, 32: data width in bits; legal values 32 or 64.
- ADDR_W, 32: AWADDR/ARADDR width.
- NUM_REGS, 8: number of registers, 1..256.
- RO_MASK, 0 (NUM_REGS bits): bit i=1 makes register i read-only from the bus.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- AWADDR  in  ADDR_W  write address.
- AWVALID  in  1.
- AWREADY  out  1.
- WDATA  in  DATA_W.
- WSTRB  in  DATA_W/8  byte strobes.
- WVALID  in  1.
- WREADY  out  1.
- BRESP  out  2  write response.
- BVALID  out  1.
- BREADY  in  1.
- ARADDR  in  ADDR_W  read address.
- ARVALID  in  1.
- ARREADY  out  1.
- RDATA  out  DATA_W.
- RRESP  out  2.
- RVALID  out  1.
- RREADY  in  1.

Behaviour:
- Reset: one clock ACLK; reset is asynchronous and active-low (ARESETN).
  - While ARESETN=0, all outputs are 0 and all registers are 0.
  - An internal ready flag goes high on the first ACLK edge after release. All READY outputs stay 0 until that flag is set.
- Decode: register index = addr >> log2(DATA_W/8). Low byte-offset bits are ignored. Index >= NUM_REGS is out of range.
- Write address: AWREADY = ready_flag & !aw_held & !BVALID. An AW handshake latches the address and sets aw_held.
- Write data: WREADY = ready_flag & !w_held & !BVALID. A W handshake latches WDATA/WSTRB and sets w_held.
- Write commit: occurs on the edge where an address and data are both available, from either a held copy or a handshake in the same cycle.
  - In range and not RO: each byte lane with WSTRB=1 is updated; other lanes keep their value. BRESP=00.
  - Out of range or RO: no register changes. BRESP=10 (SLVERR).
  - On that edge BVALID<=1 and aw_held/w_held are cleared.
  - Net latency: BVALID rises 1 cycle after the later of the AW and W handshakes.
- Write response: BVALID and BRESP hold stable until BREADY=1. BVALID clears on the edge where BVALID&BREADY. Only one write is outstanding at a time.
- Read: ARREADY = ready_flag & !RVALID.
  - On an AR handshake, RDATA and RRESP are registered and RVALID<=1. Latency is 1 cycle.
  - Out of range: RDATA=0, RRESP=10. RO registers read normally with RRESP=00.
  - RDATA, RRESP and RVALID hold stable until RREADY. RVALID clears on RVALID&RREADY.
- Simultaneous events:
  - Read and write commit to the same register on the same edge: read returns the pre-write value.
  - Read and write channels are fully independent and never stall each other.
- Reset mid-transaction: held AW/W are discarded, BVALID/RVALID drop immediately, and no partial write occurs.

Optional Feature:
- Macro: AXIL_REGFILE_WRITE_IRQ_EN.
- When defined:
  - Adds output port wr_irq (1 bit), reset value 0.
  - wr_irq pulses high for exactly 1 cycle, on the same edge BVALID rises, when BRESP=00.
  - wr_irq stays 0 for SLVERR writes.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Bench overrides: NUM_REGS=8, RO_MASK=8'h80, DATA_W=32.
  - Write 0x12345678 to 0x00, then read 0x00 -> BRESP=00; RDATA=0x12345678, RRESP=00.
  - Write 0xAABBCCDD to 0x08, then write 0x00001234 with WSTRB=4'b0011 -> read 0x08 returns 0xAABB1234.
  - W handshake 3 cycles before AW to 0x0C with data 0x55555555 -> WREADY low after the W handshake; BVALID 1 cycle after the AW handshake; read 0x0C returns 0x55555555.
  - Write 0xDEADBEEF to 0x20 (out of range) and to 0x1C (RO) -> BRESP=10 for both; read 0x20 returns RDATA=0, RRESP=10; read 0x1C returns 0, RRESP=00.
  - Hold BREADY=0 for 5 cycles after a write to 0x04 -> BVALID/BRESP stable; AWREADY=WREADY=0 throughout; clears on the BREADY edge.
  - Drop ARESETN while BVALID=1 and RVALID=1 -> both are 0 immediately; all registers read 0 after release; READY outputs stay 0 for the first post-release cycle.

Source files
------------

// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite register-file slave: parametrised width/depth, per-register read-only mask.
// Optional write-complete pulse output wr_irq enabled by AXIL_REGFILE_WRITE_IRQ_EN.
module axi4_lite_regfile_slave #(
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0]  RO_MASK  = '0
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RVALID,
  input  logic                RREADY
`ifdef AXIL_REGFILE_WRITE_IRQ_EN
  ,
  output logic                wr_irq
`endif
);

  localparam int unsigned StrbW    = DATA_W / 8;
  localparam int unsigned OffW     = $clog2(StrbW);
  localparam int unsigned IdxFullW = ADDR_W - OffW;
  localparam int unsigned IdxW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IdxFullW-1:0] NumRegsW = IdxFullW'(NUM_REGS);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  logic                ready_q;
  logic                aw_held_q, w_held_q;
  logic [IdxFullW-1:0] aw_idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [StrbW-1:0]    wstrb_q;
  logic                bvalid_q, rvalid_q;
  logic [1:0]          bresp_q, rresp_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];

  logic                aw_hs, w_hs, ar_hs, commit;
  logic [IdxFullW-1:0] w_idx_full, r_idx_full;
  logic [IdxW-1:0]     w_idx, r_idx;
  logic [DATA_W-1:0]   wdata_sel;
  logic [StrbW-1:0]    wstrb_sel;
  logic                w_in_range, r_in_range, w_ok;

  // Byte-offset address bits carry no meaning for whole-register accesses.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{AWADDR[OffW-1:0], ARADDR[OffW-1:0]};

  assign AWREADY = ready_q & ~aw_held_q & ~bvalid_q;
  assign WREADY  = ready_q & ~w_held_q & ~bvalid_q;
  assign ARREADY = ready_q & ~rvalid_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign RVALID  = rvalid_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;

  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;
  assign ar_hs = ARVALID & ARREADY;

  // Address and data may come from a held copy or a same-cycle handshake.
  assign w_idx_full = aw_held_q ? aw_idx_q : AWADDR[ADDR_W-1:OffW];
  assign wdata_sel  = w_held_q ? wdata_q : WDATA;
  assign wstrb_sel  = w_held_q ? wstrb_q : WSTRB;
  assign commit     = (aw_held_q | aw_hs) & (w_held_q | w_hs);
  assign w_idx      = w_idx_full[IdxW-1:0];
  assign w_in_range = w_idx_full < NumRegsW;
  assign w_ok       = w_in_range & ~RO_MASK[w_idx];

  assign r_idx_full = ARADDR[ADDR_W-1:OffW];
  assign r_idx      = r_idx_full[IdxW-1:0];
  assign r_in_range = r_idx_full < NumRegsW;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ready_q   <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      ready_q <= 1'b1;
      if (bvalid_q && BREADY) begin
        bvalid_q <= 1'b0;
      end
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= w_ok ? RespOkay : RespSlvErr;
        if (w_ok) begin
          for (int b = 0; b < int'(StrbW); b++) begin
            if (wstrb_sel[b]) begin
              regs_q[w_idx][b*8 +: 8] <= wdata_sel[b*8 +: 8];
            end
          end
        end
      end else begin
        if (aw_hs) begin
          aw_held_q <= 1'b1;
          aw_idx_q  <= AWADDR[ADDR_W-1:OffW];
        end
        if (w_hs) begin
          w_held_q <= 1'b1;
          wdata_q  <= WDATA;
          wstrb_q  <= WSTRB;
        end
      end
    end
  end

  // Reads sample regs_q before any same-edge write lands.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_q <= 1'b0;
      rresp_q  <= 2'b00;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rresp_q  <= r_in_range ? RespOkay : RespSlvErr;
      rdata_q  <= r_in_range ? regs_q[r_idx] : '0;
    end else if (rvalid_q && RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

`ifdef AXIL_REGFILE_WRITE_IRQ_EN
  logic wr_irq_q;
  assign wr_irq = wr_irq_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_irq_q <= 1'b0;
    end else begin
      wr_irq_q <= commit & w_ok;
    end
  end
`endif

endmodule
